// File: rtl/mem_map_pkg.sv
// Address map and register field definitions shared by the MEM stage
// and its timer.
package mem_map_pkg;

    localparam logic [31:0] PERIPH_BASE  = 32'h4000_0000;
    localparam logic [31:0] ADDR_TH      = PERIPH_BASE + 32'h00;
    localparam logic [31:0] ADDR_TL      = PERIPH_BASE + 32'h04;
    localparam logic [31:0] ADDR_TCON    = PERIPH_BASE + 32'h08;
    localparam logic [31:0] ADDR_LED     = PERIPH_BASE + 32'h0C;
    localparam logic [31:0] ADDR_SWITCH  = PERIPH_BASE + 32'h10;
    localparam logic [31:0] ADDR_DIGI    = PERIPH_BASE + 32'h14;
    localparam logic [31:0] ADDR_SYSTICK = PERIPH_BASE + 32'h18;

    localparam int TCON_EN = 0;
    localparam int TCON_IE = 1;
    localparam int TCON_IS = 2;

    // Which timer register the current access targets
    typedef enum logic [1:0] {
        TSEL_NONE,
        TSEL_TH,
        TSEL_TL,
        TSEL_TCON
    } tsel_e;

endpackage

// File: rtl/mem_timer.sv
// Interval timer: TH reload, TL count, TCON control/status, sticky irq.
module mem_timer
    import mem_map_pkg::*;
(
    input  logic        CLK,
    input  logic        reset,
    input  logic        we,
    input  tsel_e       sel,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    logic [31:0] th;
    logic [31:0] tl;
    logic [2:0]  tcon;
    logic        tl_max;

    assign tl_max = (tl == 32'hFFFF_FFFF);

    // CPU writes override the hardware update of the same register;
    // the reload uses the pre-edge TH even when TH is written this cycle.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            th   <= '0;
            tl   <= '0;
            tcon <= '0;
        end else begin
            if (we && sel == TSEL_TH)
                th <= wdata;

            if (we && sel == TSEL_TL)
                tl <= wdata;
            else if (tcon[TCON_EN])
                tl <= tl_max ? th : tl + 32'd1;

            if (we && sel == TSEL_TCON)
                tcon <= wdata[2:0];
            else if (tcon[TCON_EN] && tcon[TCON_IE] && tl_max)
                tcon[TCON_IS] <= 1'b1;
        end
    end

    always_comb begin
        rdata = '0;
        case (sel)
            TSEL_TH:   rdata = th;
            TSEL_TL:   rdata = tl;
            TSEL_TCON: rdata = {29'd0, tcon};
            default:   rdata = '0;
        endcase
    end

    assign irq = tcon[TCON_IS];

endmodule

// File: rtl/mem_stage.sv
// MEM stage: data RAM plus memory-mapped timer, LED, switch, 7-seg and
// systick peripherals with a combinational read path.
module mem_stage
    import mem_map_pkg::*;
#(
    parameter int RAM_WORDS = 256,
    parameter int SW_WIDTH  = 8
) (
    input  logic                CLK,
    input  logic                reset,
    input  logic                MemRead,
    input  logic                MemWrite,
    input  logic [31:0]         Addr,
    input  logic [31:0]         WriteData,
    input  logic [SW_WIDTH-1:0] switch,
    output logic [31:0]         ReadData,
    output logic [7:0]          led,
    output logic [11:0]         digi,
    output logic                irq
);

    localparam int AW = $clog2(RAM_WORDS);

    logic [31:0]         ram [RAM_WORDS];
    logic [31:0]         waddr;
    logic [AW-1:0]       idx;
    logic                is_ram;
    logic                addr_unused;
    logic [31:0]         systick;
    logic [SW_WIDTH-1:0] sw_s1, sw_s2;
    tsel_e               tsel;
    logic [31:0]         tmr_rdata;

    // Byte offset is dropped: every access is a whole word
    assign waddr       = {Addr[31:2], 2'b00};
    assign addr_unused = ^Addr[1:0];
    assign idx         = Addr[AW+1:2];
    assign is_ram      = (Addr[31:AW+2] == '0);

    always_comb begin
        tsel = TSEL_NONE;
        case (waddr)
            ADDR_TH:   tsel = TSEL_TH;
            ADDR_TL:   tsel = TSEL_TL;
            ADDR_TCON: tsel = TSEL_TCON;
            default:   tsel = TSEL_NONE;
        endcase
    end

    mem_timer u_timer (
        .CLK   (CLK),
        .reset (reset),
        .we    (MemWrite),
        .sel   (tsel),
        .wdata (WriteData),
        .rdata (tmr_rdata),
        .irq   (irq)
    );

    // RAM contents survive reset
    always_ff @(posedge CLK) begin
        if (MemWrite && is_ram)
            ram[idx] <= WriteData;
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            led     <= '0;
            digi    <= '0;
            systick <= '0;
            sw_s1   <= '0;
            sw_s2   <= '0;
        end else begin
            sw_s1 <= switch;
            sw_s2 <= sw_s1;
            if (MemWrite && waddr == ADDR_LED)
                led <= WriteData[7:0];
            if (MemWrite && waddr == ADDR_DIGI)
                digi <= WriteData[11:0];
            if (MemWrite && waddr == ADDR_SYSTICK)
                systick <= '0;
            else
                systick <= systick + 32'd1;
        end
    end

    always_comb begin
        ReadData = '0;
        if (MemRead) begin
            if (is_ram) begin
                ReadData = ram[idx];
            end else begin
                case (waddr)
                    ADDR_TH, ADDR_TL, ADDR_TCON: ReadData = tmr_rdata;
                    ADDR_LED:     ReadData = {24'd0, led};
                    ADDR_SWITCH:  ReadData = {{(32-SW_WIDTH){1'b0}}, sw_s2};
                    ADDR_DIGI:    ReadData = {20'd0, digi};
                    ADDR_SYSTICK: ReadData = systick;
                    default:      ReadData = '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Randomised bench for mem_stage against a cycle-level reference model.
module tb_mem_stage;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic        MemRead = 1'b0, MemWrite = 1'b0;
    logic [31:0] Addr = '0, WriteData = '0;
    logic [7:0]  switch = '0;
    logic [31:0] ReadData;
    logic [7:0]  led;
    logic [11:0] digi;
    logic        irq;

    int checks = 0;
    int failures = 0;

    mem_stage #(.RAM_WORDS(256), .SW_WIDTH(8)) dut (
        .CLK(CLK), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
        .Addr(Addr), .WriteData(WriteData), .switch(switch),
        .ReadData(ReadData), .led(led), .digi(digi), .irq(irq)
    );

    always #5 CLK = ~CLK;

    localparam logic [31:0] A_TH = 32'h4000_0000, A_TL = 32'h4000_0004,
        A_TCON = 32'h4000_0008, A_LED = 32'h4000_000C, A_SW = 32'h4000_0010,
        A_DIGI = 32'h4000_0014, A_TICK = 32'h4000_0018;

    // Reference model state
    logic [31:0] m_ram [256];
    logic [31:0] m_th, m_tl, m_tick;
    logic [2:0]  m_tcon;
    logic [7:0]  m_led, m_sw_1ago, m_sw_2ago;
    logic [11:0] m_digi;

    task automatic model_reset();
        m_th = 0; m_tl = 0; m_tcon = 0; m_led = 0; m_digi = 0; m_tick = 0;
        m_sw_1ago = 0; m_sw_2ago = 0;
    endtask

    function automatic logic [31:0] m_read(input logic rd, input logic [31:0] a);
        logic [31:0] w = a & 32'hFFFF_FFFC;
        if (!rd) return 0;
        if (w < 32'd1024) return m_ram[w >> 2];
        case (w)
            A_TH:   return m_th;
            A_TL:   return m_tl;
            A_TCON: return {29'd0, m_tcon};
            A_LED:  return {24'd0, m_led};
            A_SW:   return {24'd0, m_sw_2ago};
            A_DIGI: return {20'd0, m_digi};
            A_TICK: return m_tick;
            default: return 0;
        endcase
    endfunction

    // Advance the model by one clock edge using the inputs currently driven
    task automatic model_step();
        logic [31:0] w = Addr & 32'hFFFF_FFFC;
        logic [31:0] n_tl = m_tl;
        logic [2:0]  n_tcon = m_tcon;
        if (m_tcon[0]) begin
            if (m_tl == 32'hFFFF_FFFF) begin
                n_tl = m_th;
                if (m_tcon[1]) n_tcon[2] = 1'b1;
            end else n_tl = m_tl + 1;
        end
        m_tick = m_tick + 1;
        m_sw_2ago = m_sw_1ago;
        m_sw_1ago = switch;
        if (MemWrite) begin
            if (w < 32'd1024) m_ram[w >> 2] = WriteData;
            case (w)
                A_TH:   m_th = WriteData;
                A_TL:   n_tl = WriteData;
                A_TCON: n_tcon = WriteData[2:0];
                A_LED:  m_led = WriteData[7:0];
                A_DIGI: m_digi = WriteData[11:0];
                A_TICK: m_tick = 0;
                default: ;
            endcase
        end
        m_tl = n_tl;
        m_tcon = n_tcon;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        MemRead = rd; MemWrite = wr; Addr = a; WriteData = d;
        #1;
    endtask

    task automatic tick();
        @(posedge CLK);
        model_step();
        #1;
    endtask

    task automatic wr_cycle(input logic [31:0] a, input logic [31:0] d);
        drive(0, 1, a, d);
        tick();
    endtask

    task automatic test_reset();
        model_reset();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        reset = 1'b0;
        #1;
        checks++; if (led !== 8'h00) begin failures++; $display("FAIL reset_led got=%h exp=00", led); end
        checks++; if (digi !== 12'h000) begin failures++; $display("FAIL reset_digi got=%h exp=000", digi); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
        checks++; if (ReadData !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", ReadData); end
        foreach (m_ram[i]) ;
        for (int i = 0; i < 7; i++) begin
            logic [31:0] a = A_TH + 32'(i * 4);
            drive(1, 0, a, 0);
            checks++; if (ReadData !== m_read(1, a)) begin failures++; $display("FAIL reset_reg%0d got=%h exp=%h", i, ReadData, m_read(1, a)); end
            tick();
        end
    endtask

    task automatic test_ram();
        for (int i = 0; i < 256; i++) wr_cycle(32'(i * 4), $urandom);
        wr_cycle(32'h10, 32'hDEAD_BEEF);
        drive(1, 0, 32'h10, 0);
        checks++; if (ReadData !== 32'hDEAD_BEEF) begin failures++; $display("FAIL ram_rd10 got=%h exp=deadbeef", ReadData); end
        drive(1, 0, 32'h13, 0);
        checks++; if (ReadData !== 32'hDEAD_BEEF) begin failures++; $display("FAIL ram_rd13 got=%h exp=deadbeef", ReadData); end
        drive(1, 0, 32'h400, 0);
        checks++; if (ReadData !== 32'h0) begin failures++; $display("FAIL ram_rd400 got=%h exp=0", ReadData); end
        // read-during-write shows the old word, next cycle the new one
        drive(1, 1, 32'h10, 32'h1234_5678);
        checks++; if (ReadData !== 32'hDEAD_BEEF) begin failures++; $display("FAIL ram_rdw got=%h exp=deadbeef", ReadData); end
        tick();
        drive(1, 0, 32'h10, 0);
        checks++; if (ReadData !== 32'h1234_5678) begin failures++; $display("FAIL ram_after_rdw got=%h exp=12345678", ReadData); end
        tick();
    endtask

    task automatic test_timer_overflow();
        logic [31:0] exp_tl [5] = '{32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFE};
        logic        exp_irq [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        wr_cycle(A_TH, 32'hFFFF_FFFD);
        wr_cycle(A_TL, 32'hFFFF_FFFD);
        wr_cycle(A_TCON, 32'd3);
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, A_TL, 0);
            checks++; if (ReadData !== exp_tl[i] || irq !== exp_irq[i]) begin failures++; $display("FAIL ovf_step%0d got tl=%h irq=%b exp tl=%h irq=%b", i, ReadData, irq, exp_tl[i], exp_irq[i]); end
            tick();
        end
        wr_cycle(A_TCON, 32'd3);
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL ovf_irq_clear got=%b exp=0", irq); end
        wr_cycle(A_TCON, 32'd0);
    endtask

    task automatic test_collision();
        // TL write in the overflow cycle, interrupts enabled
        wr_cycle(A_TH, 32'h50);
        wr_cycle(A_TL, 32'hFFFF_FFFE);
        wr_cycle(A_TCON, 32'd3);
        drive(0, 0, 0, 0); tick();
        wr_cycle(A_TL, 32'h100);
        drive(1, 0, A_TL, 0);
        checks++; if (ReadData !== 32'h100 || irq !== 1'b1) begin failures++; $display("FAIL coll_tl_ie got tl=%h irq=%b exp tl=100 irq=1", ReadData, irq); end
        tick();
        wr_cycle(A_TCON, 32'd0);
        // same with interrupts disabled
        wr_cycle(A_TL, 32'hFFFF_FFFE);
        wr_cycle(A_TCON, 32'd1);
        drive(0, 0, 0, 0); tick();
        wr_cycle(A_TL, 32'h100);
        drive(1, 0, A_TL, 0);
        checks++; if (ReadData !== 32'h100 || irq !== 1'b0) begin failures++; $display("FAIL coll_tl_noie got tl=%h irq=%b exp tl=100 irq=0", ReadData, irq); end
        tick();
        // TH write in the overflow cycle reloads from the old TH
        wr_cycle(A_TCON, 32'd0);
        wr_cycle(A_TL, 32'hFFFF_FFFE);
        wr_cycle(A_TCON, 32'd1);
        drive(0, 0, 0, 0); tick();
        wr_cycle(A_TH, 32'h77);
        drive(1, 0, A_TL, 0);
        checks++; if (ReadData !== 32'h50) begin failures++; $display("FAIL coll_th_reload got=%h exp=50", ReadData); end
        tick();
        drive(1, 0, A_TH, 0);
        checks++; if (ReadData !== 32'h77) begin failures++; $display("FAIL coll_th_new got=%h exp=77", ReadData); end
        tick();
        wr_cycle(A_TCON, 32'd0);
    endtask

    task automatic test_periph();
        wr_cycle(A_LED, 32'hA5);
        checks++; if (led !== 8'hA5) begin failures++; $display("FAIL led got=%h exp=a5", led); end
        wr_cycle(A_DIGI, 32'h0FFF_F123);
        checks++; if (digi !== 12'h123) begin failures++; $display("FAIL digi got=%h exp=123", digi); end
        drive(1, 0, A_DIGI, 0);
        checks++; if (ReadData !== 32'h123) begin failures++; $display("FAIL digi_rd got=%h exp=123", ReadData); end
        tick();
        switch = 8'h11; tick(); tick();
        switch = 8'h3C;
        drive(1, 0, A_SW, 0);
        tick();
        checks++; if (ReadData !== 32'h11) begin failures++; $display("FAIL sw_cycle1 got=%h exp=11", ReadData); end
        tick();
        checks++; if (ReadData !== 32'h3C) begin failures++; $display("FAIL sw_cycle2 got=%h exp=3c", ReadData); end
        tick();
    endtask

    task automatic test_systick();
        logic [31:0] k;
        drive(1, 0, A_TICK, 0);
        k = ReadData;
        checks++; if (k !== m_tick) begin failures++; $display("FAIL tick_k got=%h exp=%h", k, m_tick); end
        repeat (5) tick();
        checks++; if (ReadData !== k + 32'd5) begin failures++; $display("FAIL tick_k5 got=%h exp=%h", ReadData, k + 32'd5); end
        drive(1, 1, A_TICK, $urandom);
        tick();
        drive(1, 0, A_TICK, 0);
        checks++; if (ReadData !== 32'd0) begin failures++; $display("FAIL tick_clr got=%h exp=0", ReadData); end
        tick();
        checks++; if (ReadData !== 32'd1) begin failures++; $display("FAIL tick_clr1 got=%h exp=1", ReadData); end
        tick();
    endtask

    task automatic test_random();
        logic [31:0] regs [8] = '{A_TH, A_TL, A_TCON, A_LED, A_SW, A_DIGI, A_TICK, 32'h4000_001C};
        int bad = 0;
        for (int n = 0; n < 400; n++) begin
            logic [31:0] a, d;
            logic rd, wr;
            case ($urandom_range(0, 3))
                0, 1: a = $urandom_range(0, 1023);
                2: a = regs[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
                default: a = ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'h400 + 32'($urandom_range(0, 255));
            endcase
            d = $urandom;
            if (a == A_TL && d[0]) d = 32'hFFFF_FFF0 | d[3:0];
            rd = 1'($urandom_range(0, 1));
            wr = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 15) == 0) switch = 8'($urandom);
            drive(rd, wr, a, d);
            checks++;
            if (ReadData !== m_read(rd, a) || led !== m_led || digi !== m_digi || irq !== m_tcon[2]) begin
                failures++; bad++;
                if (bad < 6) $display("FAIL rand%0d a=%h got rd=%h led=%h digi=%h irq=%b exp rd=%h led=%h digi=%h irq=%b",
                    n, a, ReadData, led, digi, irq, m_read(rd, a), m_led, m_digi, m_tcon[2]);
            end
            tick();
        end
        wr_cycle(A_TCON, 0);
    endtask

    task automatic test_reset_mid();
        wr_cycle(A_TH, 0);
        wr_cycle(A_TL, 32'hFFFF_FFFF);
        wr_cycle(A_TCON, 32'd3);
        wr_cycle(A_LED, 32'hFF);
        wr_cycle(A_DIGI, 32'hABC);
        wr_cycle(32'h20, 32'hCAFE_1234);
        drive(0, 0, 0, 0);
        checks++; if (irq !== 1'b1 || led !== 8'hFF) begin failures++; $display("FAIL pre_reset got irq=%b led=%h exp irq=1 led=ff", irq, led); end
        #3;
        reset = 1'b1;
        #1;
        checks++; if (led !== 8'h00 || digi !== 12'h000 || irq !== 1'b0) begin failures++; $display("FAIL mid_reset got led=%h digi=%h irq=%b exp 0", led, digi, irq); end
        model_reset();
        repeat (2) @(posedge CLK);
        #3;
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(1, 0, A_TL, 0);
            checks++; if (ReadData !== 32'h0) begin failures++; $display("FAIL post_reset_tl%0d got=%h exp=0", i, ReadData); end
            tick();
        end
        drive(1, 0, 32'h20, 0);
        checks++; if (ReadData !== 32'hCAFE_1234) begin failures++; $display("FAIL ram_keep got=%h exp=cafe1234", ReadData); end
        tick();
    endtask

    initial begin
        test_reset();
        test_ram();
        test_timer_overflow();
        test_collision();
        test_periph();
        test_systick();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
